// File: rtl/csi2_arb_pkg.sv
// Shared types and constants for the CSI-2 packet-header arbiter.
// Holds the FSM state encoding, default field widths and short-packet data types.
package csi2_arb_pkg;

  localparam int DEF_WC_W = 16;
  localparam int DEF_DT_W = 6;
  localparam int DEF_VC_W = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  // CSI-2 synchronisation short-packet data types
  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;
  localparam logic [5:0] DT_LS = 6'h02;
  localparam logic [5:0] DT_LE = 6'h03;

endpackage

// File: rtl/csi2_hdr_arbiter_rr_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & mask) at or after
// ptr, searching upward and wrapping from NUM_CH-1 back to 0.
module rr_pick #(
  parameter  int NUM_CH = 4,
  localparam int PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] mask,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt_oh,
  output logic [PTR_W-1:0]  gnt_idx,
  output logic              valid
);

  logic [NUM_CH-1:0] cand;

  assign cand = req & mask;

  // NOTE: every output gets a default before the loop so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    int k;
    gnt_oh  = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    k       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_CH) k = k - NUM_CH;
      if (!valid && cand[k[PTR_W-1:0]]) begin
        valid                  = 1'b1;
        gnt_idx                = k[PTR_W-1:0];
        gnt_oh[k[PTR_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/csi2_hdr_arbiter_rr.sv
// Round-robin header arbiter feeding the cmos2dphy transmitter: grants one
// header buffer at a time, holds the grant until xfrdone, with a watchdog abort.
module csi2_hdr_arbiter_rr
  import csi2_arb_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int WC_W        = DEF_WC_W,
  parameter int DT_W        = DEF_DT_W,
  parameter int VC_W        = DEF_VC_W,
  parameter int SP_PRIO     = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   c2d_rdy_i,
  input  logic [NUM_CH-1:0]      hdr_req_i,
  input  logic [NUM_CH*WC_W-1:0] hdr_wdcnt_i,
  input  logic [NUM_CH*DT_W-1:0] hdr_dtype_i,
  input  logic [NUM_CH*VC_W-1:0] hdr_chid_i,
  input  logic [NUM_CH-1:0]      hdr_sptype_i,
  input  logic [NUM_CH-1:0]      hdr_rd_lbfr_en_i,
  input  logic [NUM_CH-1:0]      hdr_xfrdone_i,
  output logic                   arb_sp_req_o,
  output logic                   arb_lp_start_o,
  output logic                   arb_c2dreq_o,
  output logic [WC_W-1:0]        arb_wdcnt_o,
  output logic [DT_W-1:0]        arb_dtype_o,
  output logic [VC_W-1:0]        arb_chid_o,
  output logic                   arb_sptype_o,
  output logic [NUM_CH-1:0]      arb_gnt_o,
  output logic                   arb_lbfr_rd_en_o,
  output logic                   arb_rdy_o,
  output logic                   arb_timeout_o
);

  localparam int PTR_W = $clog2(NUM_CH);
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);

  arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, idx_q, pick_idx;
  logic [NUM_CH-1:0] cand_mask, pick_oh;
  logic              pick_vld;
  logic [CNT_W-1:0]  wd_cnt_q;
  logic              timeout_q;
  logic              accept, release_done, abort;
  logic              done_hit, wd_expired;

  // Short packets, when any are pending, shrink the candidate set to themselves
  always_comb begin
    cand_mask = '1;
    if (SP_PRIO != 0 && |(hdr_req_i & hdr_sptype_i)) cand_mask = hdr_sptype_i;
  end

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .req     (hdr_req_i),
    .mask    (cand_mask),
    .ptr     (ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .valid   (pick_vld)
  );

  assign done_hit   = hdr_xfrdone_i[idx_q];
  assign wd_expired = (TIMEOUT_CYC != 0) && (wd_cnt_q == WD_LAST);

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    release_done = 1'b0;
    abort        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (c2d_rdy_i && pick_vld) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (done_hit) begin
          release_done = 1'b1;
          state_d      = IDLE;
        end else if (wd_expired) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q        <= '0;
      idx_q        <= '0;
      wd_cnt_q     <= '0;
      timeout_q    <= 1'b0;
      arb_gnt_o    <= '0;
      arb_wdcnt_o  <= '0;
      arb_dtype_o  <= '0;
      arb_chid_o   <= '0;
      arb_sptype_o <= 1'b0;
    end else begin
      timeout_q <= abort;
      if (accept) begin
        idx_q        <= pick_idx;
        arb_gnt_o    <= pick_oh;
        arb_wdcnt_o  <= hdr_wdcnt_i[int'(pick_idx)*WC_W +: WC_W];
        arb_dtype_o  <= hdr_dtype_i[int'(pick_idx)*DT_W +: DT_W];
        arb_chid_o   <= hdr_chid_i[int'(pick_idx)*VC_W +: VC_W];
        arb_sptype_o <= hdr_sptype_i[pick_idx];
      end
      if (state_q == ISSUE)          wd_cnt_q <= '0;
      else if (state_q == WAIT_DONE) wd_cnt_q <= wd_cnt_q + CNT_W'(1);
      if (release_done || abort) begin
        arb_gnt_o <= '0;
        ptr_q     <= (idx_q == LAST_CH) ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign arb_rdy_o        = (state_q == IDLE);
  assign arb_c2dreq_o     = (state_q == ISSUE);
  assign arb_sp_req_o     = arb_c2dreq_o & arb_sptype_o;
  assign arb_lp_start_o   = arb_c2dreq_o & ~arb_sptype_o;
  assign arb_lbfr_rd_en_o = |(hdr_rd_lbfr_en_i & arb_gnt_o);
  assign arb_timeout_o    = timeout_q;

endmodule

// File: tb/tb_csi2_hdr_arbiter_rr.sv
// Self-checking bench for csi2_hdr_arbiter_rr: transaction-level model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_csi2_hdr_arbiter_rr;
  import csi2_arb_pkg::*;

  localparam int N       = 4;
  localparam int WC_W    = 16;
  localparam int DT_W    = 6;
  localparam int VC_W    = 2;
  localparam int SP_PRIO = 1;
  localparam int TMO     = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 c2d_rdy = 1'b0;
  logic [N-1:0]         req = '0, sptype = '0, rd_en = '0, xfrdone = '0;
  logic [N*WC_W-1:0]    wdcnt = '0;
  logic [N*DT_W-1:0]    dtype = '0;
  logic [N*VC_W-1:0]    chid = '0;

  logic                 sp_req, lp_start, c2dreq, o_sptype, lbfr, rdy, tmo_pulse;
  logic [WC_W-1:0]      o_wdcnt;
  logic [DT_W-1:0]      o_dtype;
  logic [VC_W-1:0]      o_chid;
  logic [N-1:0]         gnt;

  int checks = 0;
  int errors = 0;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  csi2_hdr_arbiter_rr #(
    .NUM_CH(N), .WC_W(WC_W), .DT_W(DT_W), .VC_W(VC_W),
    .SP_PRIO(SP_PRIO), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .c2d_rdy_i        (c2d_rdy),
    .hdr_req_i        (req),
    .hdr_wdcnt_i      (wdcnt),
    .hdr_dtype_i      (dtype),
    .hdr_chid_i       (chid),
    .hdr_sptype_i     (sptype),
    .hdr_rd_lbfr_en_i (rd_en),
    .hdr_xfrdone_i    (xfrdone),
    .arb_sp_req_o     (sp_req),
    .arb_lp_start_o   (lp_start),
    .arb_c2dreq_o     (c2dreq),
    .arb_wdcnt_o      (o_wdcnt),
    .arb_dtype_o      (o_dtype),
    .arb_chid_o       (o_chid),
    .arb_sptype_o     (o_sptype),
    .arb_gnt_o        (gnt),
    .arb_lbfr_rd_en_o (lbfr),
    .arb_rdy_o        (rdy),
    .arb_timeout_o    (tmo_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the transmitter, for how long, and
  // where the fairness pointer sits.
  typedef struct {
    int              owner;   // -1 when idle
    int              ptr;
    int              age;     // wait cycles already spent without done
    bit              issue;   // first cycle of a grant
    bit              to;
    logic [WC_W-1:0] wc;
    logic [DT_W-1:0] dt;
    logic [VC_W-1:0] vc;
    logic            sp;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.owner = -1; r.ptr = 0; r.age = 0; r.issue = 0; r.to = 0;
    r.wc = '0; r.dt = '0; r.vc = '0; r.sp = 1'b0;
    return r;
  endfunction

  function automatic model_t model_next(input model_t cur);
    model_t n;
    bit     sp_any;
    int     w, c;
    n = cur;
    n.to = 0;
    if (cur.owner < 0) begin
      if (c2d_rdy && req != '0) begin
        sp_any = (SP_PRIO != 0) && ((req & sptype) != '0);
        w = -1;
        for (int d = 0; d < N; d++) begin
          c = (cur.ptr + d) % N;
          if (w < 0 && req[c] && (!sp_any || sptype[c])) w = c;
        end
        n.owner = w;
        n.issue = 1;
        n.wc = wdcnt[w*WC_W +: WC_W];
        n.dt = dtype[w*DT_W +: DT_W];
        n.vc = chid[w*VC_W +: VC_W];
        n.sp = sptype[w];
      end
    end else if (cur.issue) begin
      n.issue = 0;
      n.age = 0;
    end else if (xfrdone[cur.owner]) begin
      n.ptr = (cur.owner + 1) % N;
      n.owner = -1;
    end else if (cur.age == TMO - 1) begin
      n.to = 1;
      n.ptr = (cur.owner + 1) % N;
      n.owner = -1;
    end else begin
      n.age = cur.age + 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m);
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] e_gnt;
    logic         e_lbfr;
    e_gnt  = (m.owner >= 0) ? (N'(1) << m.owner) : '0;
    e_lbfr = (m.owner >= 0) ? rd_en[m.owner] : 1'b0;
    check("cyc_gnt", gnt, e_gnt);
    check("cyc_rdy", rdy, m.owner < 0);
    check("cyc_c2dreq", c2dreq, m.issue);
    check("cyc_sp_req", sp_req, m.issue & m.sp);
    check("cyc_lp_start", lp_start, m.issue & ~m.sp);
    check("cyc_timeout", tmo_pulse, m.to);
    check("cyc_wdcnt", o_wdcnt, m.wc);
    check("cyc_dtype", o_dtype, m.dt);
    check("cyc_chid", o_chid, m.vc);
    check("cyc_sptype", o_sptype, m.sp);
    check("cyc_lbfr", lbfr, e_lbfr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [WC_W-1:0] wc, input logic [DT_W-1:0] dt,
                        input logic [VC_W-1:0] vc, input logic sp);
    wdcnt[k*WC_W +: WC_W] = wc;
    dtype[k*DT_W +: DT_W] = dt;
    chid[k*VC_W +: VC_W]  = vc;
    sptype[k]             = sp;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Waits (bounded) for a grant, checks it, holds, then completes it
  task automatic xfer(input int exp_ch, input int hold);
    int waited = 0;
    while (gnt == '0 && waited < 20) begin
      tick();
      waited++;
    end
    check($sformatf("grant_ch%0d", exp_ch), gnt, N'(1) << exp_ch);
    repeat (hold) tick();
    xfrdone = N'(1) << exp_ch;
    tick();
    xfrdone = '0;
    check("idle_gap_gnt", gnt, 0);
    check("idle_gap_rdy", rdy, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    #2;
    check("rst_rdy", rdy, 1);
    check("rst_gnt", gnt, 0);
    check("rst_wdcnt", o_wdcnt, 0);
    check("rst_c2dreq", c2dreq, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single long packet on ch2
    set_ch(2, 16'h0F00, 6'h2B, 2'd1, 1'b0);
    req = 4'b0100;
    c2d_rdy = 1'b1;
    tick();
    check("t1_gnt", gnt, 4'b0100);
    check("t1_lp_start", lp_start, 1);
    check("t1_c2dreq", c2dreq, 1);
    check("t1_sp_req", sp_req, 0);
    check("t1_wdcnt", o_wdcnt, 16'h0F00);
    check("t1_dtype", o_dtype, 6'h2B);
    check("t1_chid", o_chid, 2'd1);
    req = '0;
    rd_en = 4'b0100;
    tick();
    check("t1_pulse_end", c2dreq, 0);
    check("t1_lbfr_own", lbfr, 1);
    rd_en = 4'b0001;
    tick();
    check("t1_lbfr_other", lbfr, 0);
    rd_en = '0;
    repeat (2) tick();
    xfrdone = 4'b0100;
    tick();
    xfrdone = '0;
    check("t1_done_gnt", gnt, 0);
    check("t1_done_rdy", rdy, 1);

    // Round-robin fairness, long packets only
    do_reset();
    for (int k = 0; k < N; k++) set_ch(k, WC_W'(16'h0100 + k), 6'h2A, VC_W'(k), 1'b0);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) xfer(exp_order[i], 3);
    req = '0;

    // Short-packet priority from pointer 0
    do_reset();
    set_ch(0, 16'h0200, 6'h2B, 2'd0, 1'b0);
    set_ch(3, 16'h0001, DT_FE, 2'd0, 1'b1);
    req = 4'b1001;
    tick();
    check("sp_gnt", gnt, 4'b1000);
    check("sp_req", sp_req, 1);
    check("sp_lp_start", lp_start, 0);
    check("sp_dtype", o_dtype, 6'h01);
    repeat (2) tick();
    xfrdone = 4'b1000;
    req = 4'b0001;
    tick();
    xfrdone = '0;
    xfer(0, 2);
    req = '0;
    sptype = '0;

    // Back-pressure: no grant while the transmitter is busy
    c2d_rdy = 1'b0;
    req = 4'b0110;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_gnt", gnt, 0);
      check("bp_rdy", rdy, 1);
    end
    c2d_rdy = 1'b1;
    tick();
    check("bp_release_gnt", gnt, 4'b0010);
    req = '0;
    xfer(1, 2);

    // Watchdog: ch1 never completes, stray done on ch0 ignored
    req = 4'b0010;
    tick();
    check("wd_gnt", gnt, 4'b0010);
    req = '0;
    for (int i = 1; i <= 8; i++) begin
      xfrdone = (i == 3) ? 4'b0001 : 4'b0000;
      tick();
      check("wd_hold_gnt", gnt, 4'b0010);
      check("wd_no_timeout", tmo_pulse, 0);
    end
    xfrdone = '0;
    tick();
    check("wd_timeout", tmo_pulse, 1);
    check("wd_gnt_clr", gnt, 0);
    check("wd_rdy", rdy, 1);
    tick();
    check("wd_pulse_end", tmo_pulse, 0);
    req = 4'b1111;
    tick();
    check("wd_ptr2_gnt", gnt, 4'b0100);
    req = '0;
    xfer(2, 2);

    // Asynchronous reset in the middle of a transfer
    set_ch(3, 16'hABCD, 6'h2C, 2'd3, 1'b0);
    req = 4'b1000;
    tick();
    check("mr_gnt", gnt, 4'b1000);
    req = '0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mr_async_gnt", gnt, 0);
    check("mr_async_rdy", rdy, 1);
    check("mr_async_wdcnt", o_wdcnt, 0);
    check("mr_async_chid", o_chid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    req = 4'b1111;
    tick();
    check("mr_ptr0_gnt", gnt, 4'b0001);
    req = '0;
    xfer(0, 2);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
